bram_port_arbiter: RTL and testbench



---
 rtl/bram_port_arbiter_if.sv | 34 +++
 rtl/bram_port_arbiter.sv | 88 ++++++++
 tb/tb_bram_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Bundle of the client request/grant signals and the BRAM port driven by bram_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the clients' and BRAM's view.
interface bram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_grant;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_grant;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [3:0]            bram_we;
  logic                  bram_en;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_dout,
    output wr_grant, rd_grant, rd_data, rd_valid, busy,
           bram_addr, bram_din, bram_we, bram_en
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_dout,
    input  wr_grant, rd_grant, rd_data, rd_valid, busy,
           bram_addr, bram_din, bram_we, bram_en
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port between a write client and a read client,
// with a registered command and a read-valid strobe aligned to the BRAM read latency.
module bram_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1   // legal range 1..3
) (
  input logic                clk,
  input logic                reset,
  bram_port_arbiter_if.slave bus
);

  // Handshake: a request is accepted in any cycle where req and its grant are both
  // high; the client must then present its next address/data or drop req on the
  // following cycle. Nothing is buffered here, so an ungranted req simply waits.

  logic                    last_was_write;
  logic                    rd_cmd;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_din;
  logic [3:0]              cmd_we;
  logic                    cmd_en;

  // Under contention the side that did not win last time gets the port.
  always_comb begin
    bus.wr_grant = 1'b0;
    bus.rd_grant = 1'b0;
    if (!reset) begin
      if (bus.wr_req && bus.rd_req) begin
        bus.wr_grant = !last_was_write;
        bus.rd_grant = last_was_write;
      end else begin
        bus.wr_grant = bus.wr_req;
        bus.rd_grant = bus.rd_req;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_was_write <= 1'b0;
      rd_cmd         <= 1'b0;
      cmd_en         <= 1'b0;
      cmd_we         <= 4'b0000;
      cmd_addr       <= '0;
      cmd_din        <= '0;
    end else begin
      rd_cmd <= bus.rd_grant;
      if (bus.wr_grant) begin
        last_was_write <= 1'b1;
        cmd_en         <= 1'b1;
        cmd_we         <= 4'b1111;
        cmd_addr       <= bus.wr_addr;
        cmd_din        <= bus.wr_data;
      end else if (bus.rd_grant) begin
        last_was_write <= 1'b0;
        cmd_en         <= 1'b1;
        cmd_we         <= 4'b0000;
        cmd_addr       <= bus.rd_addr;
      end else begin
        cmd_en <= 1'b0;
        cmd_we <= 4'b0000;
      end
    end
  end

  // One flag per cycle of BRAM latency; the tail marks the cycle bram_dout is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_cmd;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign bus.bram_en   = cmd_en;
  assign bus.bram_we   = cmd_we;
  assign bus.bram_addr = cmd_addr;
  assign bus.bram_din  = cmd_din;
  assign bus.rd_valid  = rd_pipe[READ_LATENCY-1];
  assign bus.rd_data   = bus.bram_dout;
  assign bus.busy      = rd_cmd | (|rd_pipe);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: three instances (read latency 1, 2, 3) share one stimulus
// stream; each has its own BRAM model, reference model and expected-value queues.
module tb_bram_port_arbiter;
  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int MEM_WORDS = 256;
  localparam int CW        = 32 + 1 + AW + DW;  // {due cycle, is_write, addr, data}
  localparam int RW        = 32 + DW;           // {due cycle, data}

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          sweep_done = 1'b0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  // ---------------- DUT lanes ----------------
  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L = g + 1;

    bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic [DW-1:0] bram_mem [MEM_WORDS];
    bit            bram_written [MEM_WORDS];
    logic [DW-1:0] dout_pipe [L];
    logic [DW-1:0] m_mem [MEM_WORDS];
    logic          m_lww = 1'b0;
    logic          m_wg = 1'b0;
    logic          m_rg = 1'b0;
    logic [CW-1:0] cmd_q [$];
    logic [RW-1:0] exp_q [$];

    assign bus.wr_req    = wr_req;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.rd_req    = rd_req;
    assign bus.rd_addr   = rd_addr;
    assign bus.bram_dout = dout_pipe[L-1];

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    // BRAM model: unwritten word at byte address a holds a; data appears L cycles after en.
    always @(posedge clk) begin
      if (bus.bram_en && bus.bram_we == 4'b1111) begin
        bram_mem[bus.bram_addr[9:2]]     <= bus.bram_din;
        bram_written[bus.bram_addr[9:2]] <= 1'b1;
      end
      if (bus.bram_en && bus.bram_we == 4'b0000)
        dout_pipe[0] <= bram_written[bus.bram_addr[9:2]] ? bram_mem[bus.bram_addr[9:2]]
                                                          : DW'({bus.bram_addr[9:2], 2'b00});
      else
        dout_pipe[0] <= '0;
      for (int i = 1; i < L; i++) dout_pipe[i] <= dout_pipe[i-1];
    end

    // Reference model: decides each grant from the arbitration rule, pushes expectations.
    initial begin
      for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = DW'(i * 4);
      forever begin
        @(negedge clk);
        if (reset) begin
          m_lww = 1'b0;
          m_wg  = 1'b0;
          m_rg  = 1'b0;
          cmd_q.delete();
          exp_q.delete();
          chk($sformatf("lat%0d wr_grant_in_reset", L), bus.wr_grant, 0);
          chk($sformatf("lat%0d rd_grant_in_reset", L), bus.rd_grant, 0);
        end else begin
          m_wg = wr_req && (!rd_req || !m_lww);
          m_rg = rd_req && !m_wg;
          chk($sformatf("lat%0d wr_grant", L), bus.wr_grant, m_wg);
          chk($sformatf("lat%0d rd_grant", L), bus.rd_grant, m_rg);
          chk($sformatf("lat%0d both_grants", L), bus.wr_grant & bus.rd_grant, 0);
          if (m_wg) begin
            cmd_q.push_back({32'(cyc + 1), 1'b1, wr_addr, wr_data});
            m_mem[wr_addr[9:2]] = wr_data;
            m_lww = 1'b1;
          end
          if (m_rg) begin
            cmd_q.push_back({32'(cyc + 1), 1'b0, rd_addr, DW'(0)});
            exp_q.push_back({32'(cyc + 1 + L), m_mem[rd_addr[9:2]]});
            m_lww = 1'b0;
          end
        end
      end
    end

    // Monitor: pops an expectation whenever one falls due, otherwise demands an idle port.
    initial begin
      logic [CW-1:0] c;
      logic [RW-1:0] r;
      logic [AW-1:0] held_addr;
      logic [DW-1:0] held_din;
      logic          exp_busy;
      held_addr = '0;
      held_din  = '0;
      forever begin
        @(negedge clk);
        if (reset) begin
          held_addr = '0;
          held_din  = '0;
          chk($sformatf("lat%0d rst bram_en", L),   bus.bram_en, 0);
          chk($sformatf("lat%0d rst bram_we", L),   bus.bram_we, 0);
          chk($sformatf("lat%0d rst bram_addr", L), bus.bram_addr, 0);
          chk($sformatf("lat%0d rst bram_din", L),  bus.bram_din, 0);
          chk($sformatf("lat%0d rst rd_valid", L),  bus.rd_valid, 0);
          chk($sformatf("lat%0d rst busy", L),      bus.busy, 0);
        end else begin
          exp_busy = (exp_q.size() > 0) && (int'(exp_q[0][RW-1 -: 32]) - L <= cyc);
          chk($sformatf("lat%0d busy", L), bus.busy, exp_busy);
          if (cmd_q.size() > 0 && int'(cmd_q[0][CW-1 -: 32]) == cyc) begin
            c = cmd_q.pop_front();
            chk($sformatf("lat%0d cmd bram_en", L),   bus.bram_en, 1);
            chk($sformatf("lat%0d cmd bram_we", L),   bus.bram_we, c[AW+DW] ? 4'b1111 : 4'b0000);
            chk($sformatf("lat%0d cmd bram_addr", L), bus.bram_addr, c[DW +: AW]);
            if (c[AW+DW]) held_din = c[DW-1:0];
            chk($sformatf("lat%0d cmd bram_din", L),  bus.bram_din, held_din);
            held_addr = c[DW +: AW];
          end else begin
            chk($sformatf("lat%0d idle bram_en", L),   bus.bram_en, 0);
            chk($sformatf("lat%0d idle bram_we", L),   bus.bram_we, 0);
            chk($sformatf("lat%0d idle bram_addr", L), bus.bram_addr, held_addr);
            chk($sformatf("lat%0d idle bram_din", L),  bus.bram_din, held_din);
          end
          if (exp_q.size() > 0 && int'(exp_q[0][RW-1 -: 32]) == cyc) begin
            r = exp_q.pop_front();
            chk($sformatf("lat%0d rd_valid", L), bus.rd_valid, 1);
            chk($sformatf("lat%0d rd_data", L),  bus.rd_data, r[DW-1:0]);
          end else begin
            chk($sformatf("lat%0d spurious rd_valid", L), bus.rd_valid, 0);
          end
        end
      end
    end

    initial begin
      wait (sweep_done);
      chk($sformatf("lat%0d leftover commands", L), cmd_q.size(), 0);
      chk($sformatf("lat%0d leftover reads", L),    exp_q.size(), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After a grant the client moves to fresh address/data; an ungranted request holds.
  task automatic refresh(input bit randomize_req);
    if (!wr_req || lane[0].m_wg) begin
      if (randomize_req) wr_req = ($urandom_range(0, 2) != 0);
      wr_addr = rand_addr();
      wr_data = $urandom;
    end
    if (!rd_req || lane[0].m_rg) begin
      if (randomize_req) rd_req = ($urandom_range(0, 2) != 0);
      rd_addr = rand_addr();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back reads of words 0,4,8,12
    for (int i = 0; i < 4; i++) begin
      rd_req  = 1'b1;
      rd_addr = AW'(i * 4);
      tick();
    end
    rd_req = 1'b0;
    repeat (6) tick();

    // Single read with READ_LATENCY=2 (lane 1)
    rd_req  = 1'b1;
    rd_addr = 32'hB000_0010;
    @(negedge clk);
    chk("t2 rd_grant", lane[1].bus.rd_grant, 1);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("t2 bram_en", lane[1].bus.bram_en, 1);
    chk("t2 bram_we", lane[1].bus.bram_we, 0);
    chk("t2 busy n+1", lane[1].bus.busy, 1);
    tick();
    @(negedge clk);
    chk("t2 busy n+2", lane[1].bus.busy, 1);
    chk("t2 rd_valid early", lane[1].bus.rd_valid, 0);
    tick();
    @(negedge clk);
    chk("t2 rd_valid n+3", lane[1].bus.rd_valid, 1);
    chk("t2 rd_data", lane[1].bus.rd_data, 32'h0000_0010);
    tick();
    @(negedge clk);
    chk("t2 rd_valid n+4", lane[1].bus.rd_valid, 0);
    repeat (3) tick();

    // Single write
    wr_req  = 1'b1;
    wr_addr = 32'hB000_2000;
    wr_data = 32'h0102_0304;
    @(negedge clk);
    chk("t1 wr_grant", lane[0].bus.wr_grant, 1);
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    chk("t1 bram_en", lane[0].bus.bram_en, 1);
    chk("t1 bram_we", lane[0].bus.bram_we, 4'b1111);
    chk("t1 bram_addr", lane[0].bus.bram_addr, 32'hB000_2000);
    chk("t1 bram_din", lane[0].bus.bram_din, 32'h0102_0304);
    tick();
    @(negedge clk);
    chk("t1 bram_en off", lane[0].bus.bram_en, 0);
    repeat (3) tick();

    // Contention straight out of reset: W,R,W,R,W,R
    reset = 1'b1;
    repeat (2) tick();
    reset   = 1'b0;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    wr_addr = rand_addr();
    wr_data = $urandom;
    rd_addr = rand_addr();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t3 wr_grant %0d", k), lane[0].bus.wr_grant, (k % 2) == 0);
      chk($sformatf("t3 rd_grant %0d", k), lane[0].bus.rd_grant, (k % 2) == 1);
      tick();
      refresh(1'b0);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (8) tick();

    // Reset one cycle after a read grant, READ_LATENCY=3 (lane 2)
    rd_req  = 1'b1;
    rd_addr = 32'h0000_0040;
    @(negedge clk);
    chk("t5 rd_grant", lane[2].bus.rd_grant, 1);
    tick();
    rd_req = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("t5 bram_en in reset", lane[2].bus.bram_en, 0);
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t5 no rd_valid %0d", k), lane[2].bus.rd_valid, 0);
      tick();
    end

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      tick();
      refresh(1'b1);
    end
    tick();
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (10) tick();

    sweep_done = 1'b1;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
